// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
// Holds the operand width, the control states and the Booth digit encoding.
package booth_multiplier_pkg;

  localparam int WIDTH = 8;
  // The partial product needs two guard bits so that +/-2M fits without wrap.
  localparam int PW    = WIDTH + 2;
  localparam int CW    = 2;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_A = 2'd1,
    GET_B = 2'd2,
    CALC  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } digit_t;

  // Map a {Q[1],Q[0],q_-1} window to its Booth digit.
  function automatic digit_t booth_digit(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = PM;
      3'b011:         d = P2M;
      3'b100:         d = N2M;
      3'b101, 3'b110: d = NM;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Operand/result bus between the controller (master) and the multiplier (slave).
// Handshake: the master strobes get 0->1 to present in; the slave raises ready
// with out once a product is complete and holds both until the next A capture.
interface booth_multiplier_if;
  import booth_multiplier_pkg::*;

  logic [WIDTH-1:0]   in;
  logic               start;
  logic               get;
  logic               ready;
  logic [2*WIDTH-1:0] out;

  modport master (output in, output start, output get, input ready, input out);
  modport slave  (input in, input start, input get, output ready, output out);

endinterface

// File: rtl/booth_multiplier_booth_recoder.sv
// Combinational Booth recoder: 3-bit multiplier window plus multiplicand M
// gives the signed 10-bit addend for one radix-4 iteration.
module booth_recoder
  import booth_multiplier_pkg::*;
(
  input  logic [2:0]       window,
  input  logic [WIDTH-1:0] m,
  output logic [PW-1:0]    addend
);

  logic [PW-1:0] m_ext;
  logic [PW-1:0] m2_ext;
  digit_t        digit;

  assign m_ext  = {{(PW-WIDTH){m[WIDTH-1]}}, m};
  assign m2_ext = {m_ext[PW-2:0], 1'b0};
  assign digit  = booth_digit(window);

  // Select 0, +/-M or +/-2M according to the recoded digit.
  always_comb begin
    addend = '0;
    case (digit)
      PM:      addend = m_ext;
      P2M:     addend = m2_ext;
      NM:      addend = ~m_ext + PW'(1);
      N2M:     addend = ~m2_ext + PW'(1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-4 Booth multiplier with a two-operand streaming
// front end. Operands arrive on get rising edges; the product appears with
// ready four clocks after the second operand is captured.
module booth_multiplier
  import booth_multiplier_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  booth_multiplier_if.slave   bus,
  output state_t              state_dbg
);

  state_t             state_q, state_d;
  logic               get_d_q, get_d_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [PW-1:0]      p_q, p_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic                     get_rise;
  logic [PW-1:0]            addend;
  logic [PW-1:0]            sum;
  logic signed [PW+WIDTH:0] combo;
  logic signed [PW+WIDTH:0] shifted;

  booth_recoder u_recoder (
    .window (({q_q[1:0], qm1_q})),
    .m      (m_q),
    .addend (addend)
  );

  assign get_rise  = bus.get & ~get_d_q;
  assign sum       = p_q + addend;
  assign combo     = {sum, q_q, qm1_q};
  assign shifted   = combo >>> 2;
  assign bus.ready = ready_q;
  assign bus.out   = out_q;
  assign state_dbg = state_q;

  // Next-state, operand capture and Booth iteration.
  always_comb begin
    state_d = state_q;
    get_d_d = bus.get;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    ready_d = ready_q;
    out_d   = out_q;
    if (bus.start && state_q != IDLE) begin
      // Abort whatever is in flight and wait for a fresh A.
      ready_d = 1'b0;
      state_d = GET_A;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = GET_A;
        end
        GET_A: begin
          if (get_rise) begin
            m_d     = bus.in;
            ready_d = 1'b0;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (get_rise) begin
            q_d     = bus.in;
            p_d     = '0;
            qm1_d   = 1'b0;
            count_d = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          // get strobes here are deliberately dropped.
          p_d     = shifted[PW+WIDTH:WIDTH+1];
          q_d     = shifted[WIDTH:1];
          qm1_d   = shifted[0];
          count_d = count_q + CW'(1);
          if (count_q == LAST_ITER) begin
            out_d   = shifted[2*WIDTH:1];
            ready_d = 1'b1;
            state_d = GET_A;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      get_d_q <= 1'b0;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      get_d_q <= get_d_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier with a product scoreboard.
module tb_booth_multiplier;
  import booth_multiplier_pkg::*;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     checks;
  int     failures;
  logic [15:0] exp_q[$];

  booth_multiplier_if bus();

  booth_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One operand strobe; get low across at least one edge before it rises.
  task automatic pulse_get(input logic [7:0] val, input int hold);
    @(negedge clk);
    bus.in  = val;
    bus.get = 1'b1;
    repeat (hold) @(negedge clk);
    bus.get = 1'b0;
  endtask

  // Send A then B; the expected product goes to the scoreboard when wanted.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int hold,
                           input bit expect_result);
    logic signed [7:0]  sa;
    logic signed [7:0]  sb;
    logic signed [15:0] prod;
    sa   = a;
    sb   = b;
    prod = sa * sb;
    if (expect_result) exp_q.push_back(prod);
    pulse_get(a, hold);
    check("ready_drop_on_a", bus.ready, 0);
    pulse_get(b, hold);
  endtask

  task automatic wait_result(input bit check_lat, input int exp_lat);
    int n;
    logic [15:0] exp;
    n = 0;
    while (!bus.ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", bus.ready, 1);
    if (check_lat) check("latency", n, exp_lat);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("product", bus.out, exp);
    end else begin
      check("scoreboard_empty", exp_q.size(), 1);
    end
  endtask

  initial begin
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus.in    = 8'h00;
    bus.start = 1'b0;
    bus.get   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", bus.ready, 0);
    check("reset_out", bus.out, 16'h0000);
    check("reset_state", state_dbg, IDLE);
    rst = 1'b0;

    // get without start does nothing
    pulse_get(8'h33, 4);
    check("idle_get_state", state_dbg, IDLE);
    check("idle_get_ready", bus.ready, 0);

    // basic pair with latency
    pulse_start();
    check("start_state", state_dbg, GET_A);
    send_pair(8'hF9, 8'hFF, 1, 1'b1);
    wait_result(1'b1, 4);
    check("basic_out", bus.out, 16'h0007);

    // ready stays up through GET_A
    repeat (3) @(negedge clk);
    check("ready_hold", bus.ready, 1);

    // back-to-back without start
    send_pair(8'hF8, 8'hFF, 1, 1'b1);
    wait_result(1'b1, 4);

    // extremes
    ea[0] = 8'h80; eb[0] = 8'h80;
    ea[1] = 8'h7F; eb[1] = 8'h80;
    ea[2] = 8'h00; eb[2] = 8'h5A;
    ea[3] = 8'h7F; eb[3] = 8'h7F;
    for (int i = 0; i < 4; i++) begin
      send_pair(ea[i], eb[i], 1, 1'b1);
      wait_result(1'b1, 4);
    end
    check("ext_last_out", bus.out, 16'h3F01);

    // long strobes
    send_pair(8'h5A, 8'hC3, 4, 1'b1);
    wait_result(1'b0, 0);
    check("long_get_state", state_dbg, GET_A);

    // get rise during CALC is dropped
    send_pair(8'h13, 8'hE5, 1, 1'b1);
    pulse_get(8'h11, 1);
    wait_result(1'b0, 0);
    check("calc_get_state", state_dbg, GET_A);

    // start aborts CALC
    send_pair(8'h21, 8'h42, 1, 1'b0);
    pulse_start();
    check("abort_ready", bus.ready, 0);
    check("abort_state", state_dbg, GET_A);
    repeat (6) @(negedge clk);
    check("abort_no_result", bus.ready, 0);
    send_pair(8'hC0, 8'h09, 1, 1'b1);
    wait_result(1'b1, 4);

    // asynchronous reset during CALC
    send_pair(8'h44, 8'h55, 1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_out", bus.out, 16'h0000);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_pair(8'h9C, 8'h64, 1, 1'b1);
    wait_result(1'b1, 4);

    // random pairs
    for (int i = 0; i < 16; i++) begin
      send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                int'($urandom_range(1, 3)), 1'b1);
      wait_result(1'b0, 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
